gf180mcu_fd_sc_mcu7t5v0__norn_dbnc: RTL and testbench

GF180MCU_FD_SC_MCU7T5V0__NORN_DBNC -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__norn_dbnc

---
 rtl/gf180mcu_fd_sc_mcu7t5v0__norn_dbnc_if.sv | 36 +++
 rtl/gf180mcu_fd_sc_mcu7t5v0__norn_dbnc.sv | 112 +++++++++++
 tb/tb_gf180mcu_fd_sc_mcu7t5v0__norn_dbnc.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__norn_dbnc_if.sv
// Signal bundle for the debounced NOR cell.
//   A      : data inputs to the NOR reduction (WIDTH bits)
//   EN     : qualification enable
//   MODE   : 0 = level mode, 1 = sticky mode
//   CLR    : synchronous clear of filter state and ZN
//   ZN_RAW : registered NOR of A
//   ZN     : debounced NOR result
// master drives the inputs and observes the results; slave is the cell itself.
interface gf180mcu_fd_sc_mcu7t5v0__norn_dbnc_if #(
  parameter int unsigned WIDTH = 3
);
  logic [WIDTH-1:0] A;
  logic             EN;
  logic             MODE;
  logic             CLR;
  logic             ZN_RAW;
  logic             ZN;

  modport master (
    output A,
    output EN,
    output MODE,
    output CLR,
    input  ZN_RAW,
    input  ZN
  );

  modport slave (
    input  A,
    input  EN,
    input  MODE,
    input  CLR,
    output ZN_RAW,
    output ZN
  );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__norn_dbnc.sv
// Debounced WIDTH-input NOR. ZN_RAW is the NOR of A registered every edge. ZN rises only
// after FILT consecutive edges with EN=1 and ZN_RAW=1; in level mode it falls one edge
// after ZN_RAW falls, in sticky mode it holds until CLR or reset.
//   CLK     : clock, rising edge
//   RN      : asynchronous active-low reset
//   VDD/VSS : supply pins, no functional effect
//   bus     : A/EN/MODE/CLR in, ZN_RAW/ZN out (slave modport)
module gf180mcu_fd_sc_mcu7t5v0__norn_dbnc #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned FILT  = 4
) (
  input  logic CLK,
  input  logic RN,
  inout  wire  VDD,
  inout  wire  VSS,
  gf180mcu_fd_sc_mcu7t5v0__norn_dbnc_if.slave bus
);

  localparam int unsigned CntW = $clog2(FILT + 1);
  localparam logic [CntW-1:0] FiltC = CntW'(FILT);

  typedef enum logic [1:0] {
    StLow  = 2'b00,
    StCnt  = 2'b01,
    StHigh = 2'b10
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_inc;
  logic            zn_raw_q;
  logic            zn_q;
  logic            qualify;
  logic [WIDTH-1:0] a;

  wire unused_supply;
  assign unused_supply = VDD ^ VSS;

  assign a = bus.A;

  // Qualification uses the registered NOR, so the first edge after A settles only loads it.
  assign qualify = bus.EN & zn_raw_q;

  always_comb begin
    cnt_inc = cnt_q;
    if (cnt_q < FiltC) begin
      cnt_inc = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      zn_raw_q <= 1'b0;
      zn_q     <= 1'b0;
      cnt_q    <= '0;
      state_q  <= StLow;
    end else begin
      zn_raw_q <= ~|a;
      if (bus.CLR) begin
        state_q <= StLow;
        cnt_q   <= '0;
        zn_q    <= 1'b0;
      end else begin
        case (state_q)
          StLow: begin
            zn_q <= 1'b0;
            if (qualify) begin
              cnt_q <= {{(CntW-1){1'b0}}, 1'b1};
              if (FILT == 1) begin
                state_q <= StHigh;
                zn_q    <= 1'b1;
              end else begin
                state_q <= StCnt;
              end
            end
          end
          StCnt: begin
            if (qualify) begin
              cnt_q <= cnt_inc;
              if (cnt_inc == FiltC) begin
                state_q <= StHigh;
                zn_q    <= 1'b1;
              end
            end else begin
              cnt_q   <= '0;
              state_q <= StLow;
              zn_q    <= 1'b0;
            end
          end
          StHigh: begin
            zn_q <= 1'b1;
            // Sticky mode and EN=0 both hold; level mode falls without filtering.
            if (bus.EN && !bus.MODE && !zn_raw_q) begin
              state_q <= StLow;
              cnt_q   <= '0;
              zn_q    <= 1'b0;
            end
          end
          default: begin
            state_q <= StLow;
            cnt_q   <= '0;
            zn_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.ZN_RAW = zn_raw_q;
  assign bus.ZN     = zn_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__norn_dbnc.sv
// Self-checking bench for the debounced NOR: a per-edge vector table on the WIDTH=3/FILT=4
// instance through a scoreboard queue, plus hand sequences for reset pulses, FILT=1 and
// WIDTH=1/32 walking-one checks.
module tb_gf180mcu_fd_sc_mcu7t5v0__norn_dbnc;

  logic clk = 1'b0;
  logic rn;
  wire  vdd;
  wire  vss;
  assign vdd = 1'b1;
  assign vss = 1'b0;

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu7t5v0__norn_dbnc_if #(.WIDTH(3))  bus ();
  gf180mcu_fd_sc_mcu7t5v0__norn_dbnc_if #(.WIDTH(3))  bus_f1 ();
  gf180mcu_fd_sc_mcu7t5v0__norn_dbnc_if #(.WIDTH(1))  bus_w1 ();
  gf180mcu_fd_sc_mcu7t5v0__norn_dbnc_if #(.WIDTH(32)) bus_w32 ();

  gf180mcu_fd_sc_mcu7t5v0__norn_dbnc #(.WIDTH(3), .FILT(4)) dut (
    .CLK(clk), .RN(rn), .VDD(vdd), .VSS(vss), .bus(bus.slave)
  );
  gf180mcu_fd_sc_mcu7t5v0__norn_dbnc #(.WIDTH(3), .FILT(1)) dut_f1 (
    .CLK(clk), .RN(rn), .VDD(vdd), .VSS(vss), .bus(bus_f1.slave)
  );
  gf180mcu_fd_sc_mcu7t5v0__norn_dbnc #(.WIDTH(1), .FILT(4)) dut_w1 (
    .CLK(clk), .RN(rn), .VDD(vdd), .VSS(vss), .bus(bus_w1.slave)
  );
  gf180mcu_fd_sc_mcu7t5v0__norn_dbnc #(.WIDTH(32), .FILT(4)) dut_w32 (
    .CLK(clk), .RN(rn), .VDD(vdd), .VSS(vss), .bus(bus_w32.slave)
  );

  // One row per clock edge: inputs applied before the edge, outputs expected after it.
  typedef struct packed {
    logic [2:0] a;
    logic       en;
    logic       mode;
    logic       clr;
    logic       raw;
    logic       zn;
  } vec_t;

  typedef struct packed {
    logic raw;
    logic zn;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // c = {en, mode, clr, exp_raw, exp_zn}
  function automatic vec_t mk(input logic [2:0] a, input logic [4:0] c);
    mk = {a, c};
  endfunction

  task automatic add(input logic [2:0] a, input logic [4:0] c);
    tbl.push_back(mk(a, c));
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input vec_t v, input string nm);
    exp_t e;
    bus.A    = v.a;
    bus.EN   = v.en;
    bus.MODE = v.mode;
    bus.CLR  = v.clr;
    e.raw    = v.raw;
    e.zn     = v.zn;
    sb.push_back(e);
    edge1();
    e = sb.pop_front();
    check({nm, "_raw"}, {31'd0, bus.ZN_RAW}, {31'd0, e.raw});
    check({nm, "_zn"}, {31'd0, bus.ZN}, {31'd0, e.zn});
  endtask

  // Called just after a rising edge: pulse RN low between edges and check the async clear.
  task automatic pulse_rn(input string nm);
    #2 rn = 1'b0;
    #1;
    check({nm, "_raw"}, {31'd0, bus.ZN_RAW}, 32'd0);
    check({nm, "_zn"}, {31'd0, bus.ZN}, 32'd0);
    #1 rn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rn = 1'b0;
    bus.A = 3'b101;     bus.EN = 1'b1;     bus.MODE = 1'b0;     bus.CLR = 1'b0;
    bus_f1.A = 3'b101;  bus_f1.EN = 1'b1;  bus_f1.MODE = 1'b0;  bus_f1.CLR = 1'b0;
    bus_w1.A = 1'b1;    bus_w1.EN = 1'b1;  bus_w1.MODE = 1'b0;  bus_w1.CLR = 1'b0;
    bus_w32.A = 32'd1;  bus_w32.EN = 1'b1; bus_w32.MODE = 1'b0; bus_w32.CLR = 1'b0;

    // Level-mode rise latency, then one-edge fall.
    add(3'b101, 5'b10000);
    add(3'b000, 5'b10010);
    add(3'b000, 5'b10010);
    add(3'b000, 5'b10010);
    add(3'b000, 5'b10010);
    add(3'b000, 5'b10011);
    add(3'b001, 5'b10001);
    add(3'b001, 5'b10000);
    // Glitch after three qualifying edges restarts the count.
    add(3'b000, 5'b10010);
    add(3'b000, 5'b10010);
    add(3'b000, 5'b10010);
    add(3'b010, 5'b10000);
    add(3'b000, 5'b10010);
    add(3'b000, 5'b10010);
    add(3'b000, 5'b10010);
    add(3'b000, 5'b10010);
    add(3'b000, 5'b10011);
    // Sticky mode holds through ZN_RAW=0 and EN=0 until CLR.
    add(3'b001, 5'b11001);
    add(3'b001, 5'b11001);
    add(3'b001, 5'b01001);
    add(3'b001, 5'b11100);
    add(3'b001, 5'b10000);
    // Rise in sticky mode, then MODE 1->0 releases on that edge.
    add(3'b000, 5'b11010);
    add(3'b000, 5'b11010);
    add(3'b000, 5'b11010);
    add(3'b000, 5'b11010);
    add(3'b000, 5'b11011);
    add(3'b100, 5'b11001);
    add(3'b100, 5'b11001);
    add(3'b100, 5'b10000);
    // EN toggling 1,1,0,1 restarts the count.
    add(3'b000, 5'b10010);
    add(3'b000, 5'b10010);
    add(3'b000, 5'b00010);
    add(3'b000, 5'b10010);
    add(3'b000, 5'b10010);
    add(3'b000, 5'b10010);
    add(3'b000, 5'b10011);
    // EN=0 in the high state holds ZN in level mode.
    add(3'b001, 5'b00001);
    add(3'b001, 5'b00001);
    add(3'b001, 5'b10000);
    // CLR mid-count discards the partial count.
    add(3'b000, 5'b10010);
    add(3'b000, 5'b10010);
    add(3'b000, 5'b10010);
    add(3'b000, 5'b10110);
    add(3'b000, 5'b10010);
    add(3'b000, 5'b10010);
    add(3'b000, 5'b10010);
    add(3'b000, 5'b10011);

    #1;
    check("rst_raw", {31'd0, bus.ZN_RAW}, 32'd0);
    check("rst_zn", {31'd0, bus.ZN}, 32'd0);
    check("rst_f1_zn", {31'd0, bus_f1.ZN}, 32'd0);
    #11 rn = 1'b1;
    edge1();

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("tbl%0d", i));
    end

    // Reset pulse while high, then a fresh FILT+1 latency.
    pulse_rn("rst_high");
    for (int k = 1; k <= 5; k++) begin
      step(mk(3'b000, {4'b1001, (k == 5)}), $sformatf("rst_high_lat%0d", k));
    end
    step(mk(3'b101, 5'b10001), "fall_a");
    step(mk(3'b101, 5'b10000), "fall_b");
    step(mk(3'b000, 5'b10010), "cnt_load");
    step(mk(3'b000, 5'b10010), "cnt_1");
    step(mk(3'b000, 5'b10010), "cnt_2");
    // Reset pulse mid-count; no partial count may survive.
    pulse_rn("rst_cnt");
    for (int k = 1; k <= 5; k++) begin
      step(mk(3'b000, {4'b1001, (k == 5)}), $sformatf("rst_cnt_lat%0d", k));
    end
    check("sb_empty", sb.size(), 32'd0);

    // FILT=1: ZN rises two edges after A goes all-zero.
    bus_f1.A = 3'b000;
    edge1();
    check("f1_e1_raw", {31'd0, bus_f1.ZN_RAW}, 32'd1);
    check("f1_e1_zn", {31'd0, bus_f1.ZN}, 32'd0);
    edge1();
    check("f1_e2_zn", {31'd0, bus_f1.ZN}, 32'd1);

    // WIDTH=1 and WIDTH=32 NOR reduction.
    bus_w1.A = 1'b1;
    edge1();
    check("w1_one_raw", {31'd0, bus_w1.ZN_RAW}, 32'd0);
    bus_w1.A = 1'b0;
    edge1();
    check("w1_zero_raw", {31'd0, bus_w1.ZN_RAW}, 32'd1);
    for (int i = 0; i < 32; i++) begin
      bus_w32.A = 32'd1 << i;
      edge1();
      check($sformatf("w32_walk%0d", i), {31'd0, bus_w32.ZN_RAW}, 32'd0);
    end
    bus_w32.A = 32'd0;
    edge1();
    check("w32_zero_raw", {31'd0, bus_w32.ZN_RAW}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
